// File: rtl/sipo_rx_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package sipo_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_e;

   localparam logic IDLE_LVL  = 1'b0;
   localparam logic START_LVL = 1'b1;

endpackage

// File: rtl/sipo_frame_rx.sv
// MSB-first serial frame receiver: start bit, WIDTH data bits, optional even parity.
// Delivers the word with a one-cycle valid pulse; po/parity_err hold between frames.
module sipo_frame_rx
   import sipo_rx_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             si,
   output logic [WIDTH-1:0] po,
   output logic             valid,
   output logic             parity_err,
   output logic             busy
);

   localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;
   logic [WIDTH-1:0] po_q;
   logic             valid_q;
   logic             perr_q;
   logic             perr_d;

   assign sr_d   = {sr_q[WIDTH-2:0], si};
   // Even parity: error when data ones plus the parity bit is odd.
   assign perr_d = (^sr_q) ^ si;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         po_q    <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (en) begin
            unique case (state_q)
               IDLE: begin
                  if (si == START_LVL) begin
                     state_q <= DATA;
                     cnt_q   <= '0;
                  end
               end
               DATA: begin
                  sr_q <= sr_d;
                  if (cnt_q == LAST) begin
                     // Counter wraps to 0 here so it never reaches WIDTH.
                     cnt_q <= '0;
                     if (PARITY_EN) begin
                        state_q <= PARITY;
                     end else begin
                        state_q <= IDLE;
                        po_q    <= sr_d;
                        valid_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               PARITY: begin
                  state_q <= IDLE;
                  po_q    <= sr_q;
                  perr_q  <= perr_d;
                  valid_q <= 1'b1;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign po         = po_q;
   assign valid      = valid_q;
   assign parity_err = PARITY_EN ? perr_q : 1'b0;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Scoreboard bench: directed frames push expected {parity_err, po}; monitors pop on valid.
module tb_sipo_frame_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_a = 1'b0, si_a = 1'b0;
   logic       en_b = 1'b0, si_b = 1'b0;
   logic [3:0] po_a, po_b;
   logic       valid_a, valid_b, perr_a, perr_b, busy_a, busy_b;

   int passed = 0;
   int total  = 0;

   logic [4:0] qa[$];
   logic [4:0] qb[$];

   always #5 clk = ~clk;

   sipo_frame_rx #(.WIDTH(4), .PARITY_EN(1'b1)) u_par (
      .clk(clk), .rst(rst), .en(en_a), .si(si_a),
      .po(po_a), .valid(valid_a), .parity_err(perr_a), .busy(busy_a));

   sipo_frame_rx #(.WIDTH(4), .PARITY_EN(1'b0)) u_nopar (
      .clk(clk), .rst(rst), .en(en_b), .si(si_b),
      .po(po_b), .valid(valid_b), .parity_err(perr_b), .busy(busy_b));

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   always @(negedge clk) begin
      logic [4:0] e;
      if (!rst && valid_a === 1'b1) begin
         if (qa.size() == 0) chk("unexpected valid (parity dut)", 1, 0);
         else begin
            e = qa.pop_front();
            chk("po (parity dut)", po_a, e[3:0]);
            chk("parity_err (parity dut)", perr_a, e[4]);
         end
      end
      if (!rst && valid_b === 1'b1) begin
         if (qb.size() == 0) chk("unexpected valid (no-parity dut)", 1, 0);
         else begin
            e = qb.pop_front();
            chk("po (no-parity dut)", po_b, e[3:0]);
            chk("parity_err (no-parity dut)", perr_b, e[4]);
         end
      end
   end

   task automatic idle(input int n);
      en_a = 1'b1; si_a = 1'b0; en_b = 1'b1; si_b = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
      en_a = 1'b0; en_b = 1'b0;
   endtask

   // Stream n bits MSB first on the selected DUT; gap inserts an en=0 edge with garbage si.
   task automatic send(input bit to_b, input logic [15:0] bits, input int n, input bit gap);
      logic b;
      for (int i = 0; i < n; i++) begin
         b = bits[n-1-i];
         if (to_b) begin en_b = 1'b1; si_b = b; end
         else      begin en_a = 1'b1; si_a = b; end
         @(posedge clk); #1;
         if (gap) begin
            if (to_b) begin en_b = 1'b0; si_b = ~b; end
            else      begin en_a = 1'b0; si_a = ~b; end
            @(posedge clk); #1;
         end
      end
      en_a = 1'b0; si_a = 1'b0; en_b = 1'b0; si_b = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset po", po_a, 4'h0);
      chk("reset valid", valid_a, 1'b0);
      chk("reset parity_err", perr_a, 1'b0);
      chk("reset busy", busy_a, 1'b0);
      chk("reset busy (no-parity)", busy_b, 1'b0);
      rst = 1'b0;

      // Good frame: data 1011, parity 1
      qa.push_back({1'b0, 4'b1011});
      send(0, 16'b110111, 6, 0);
      idle(2);

      // Same data with wrong parity; flag must hold through idle
      qa.push_back({1'b1, 4'b1011});
      send(0, 16'b110110, 6, 0);
      idle(3);
      chk("parity_err held", perr_a, 1'b1);
      chk("po held", po_a, 4'b1011);
      qa.push_back({1'b0, 4'b0101});
      send(0, 16'b101010, 6, 0);
      idle(2);

      // Strobe every other cycle: data 0110, parity 0
      qa.push_back({1'b0, 4'b0110});
      send(0, 16'b101100, 6, 1);
      idle(2);

      // Abort after two data bits, then a clean frame: data 0010, parity 1
      send(0, 16'b110, 3, 0);
      chk("busy mid-frame", busy_a, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("busy after abort", busy_a, 1'b0);
      chk("po cleared by abort reset", po_a, 4'h0);
      rst = 1'b0;
      qa.push_back({1'b0, 4'b0010});
      send(0, 16'b100101, 6, 0);
      idle(2);

      // Back-to-back frames, no gap
      qa.push_back({1'b0, 4'b1111});
      qa.push_back({1'b0, 4'b0001});
      send(0, 16'b111110_100011, 12, 0);
      idle(20);
      chk("busy after idle zeros", busy_a, 1'b0);
      chk("po held after idle zeros", po_a, 4'b0001);

      // No-parity instance: data 1001 completes on the 5th bit
      qb.push_back({1'b0, 4'b1001});
      send(1, 16'b11001, 5, 0);
      chk("no-parity busy after frame", busy_b, 1'b0);
      idle(3);
      chk("no-parity po held", po_b, 4'b1001);

      chk("parity dut frames all delivered", qa.size(), 0);
      chk("no-parity dut frames all delivered", qb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
